// File: rtl/spmv_row_sched.sv
// spmv_row_sched: row-level controller for one SpMV MAC lane.
// Takes a nonzero count per row, streams (val, multiplicand) pairs into the
// MAC while bounding the number of in-flight elements, then captures the
// MAC accumulator as the row result and clears the MAC before the next row.
// Optional build macro: SPMV_ROW_SCHED_PERF_EN adds perf_rows/perf_stall
// saturating counters.
module spmv_row_sched #(
  parameter int DATA_WIDTH      = 32,
  parameter int LEN_WIDTH       = 16,
  parameter int ROW_WIDTH       = 16,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LEN_WIDTH-1:0]    row_len,
  input  logic                    row_valid,
  output logic                    row_ready,
  input  logic [2*DATA_WIDTH-1:0] elem_val,
  input  logic [DATA_WIDTH-1:0]   elem_mult,
  input  logic                    elem_valid,
  output logic                    elem_ready,
  output logic [2*DATA_WIDTH-1:0] mac_val,
  output logic [DATA_WIDTH-1:0]   mac_mult,
  output logic                    mac_in_valid,
  input  logic                    mac_in_ready,
  output logic                    mac_reset,
  input  logic [2*DATA_WIDTH-1:0] mac_acc,
  input  logic                    mac_done,
  output logic [2*DATA_WIDTH-1:0] res_data,
  output logic [ROW_WIDTH-1:0]    res_row,
  output logic                    res_valid,
  input  logic                    res_ready,
`ifdef SPMV_ROW_SCHED_PERF_EN
  output logic [31:0]             perf_rows,
  output logic [31:0]             perf_stall,
`endif
  output logic                    err
);

  // Wide enough to hold 0..MAX_OUTSTANDING inclusive.
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

  localparam logic [2:0] ST_INIT    = 3'd0;
  localparam logic [2:0] ST_IDLE    = 3'd1;
  localparam logic [2:0] ST_ISSUE   = 3'd2;
  localparam logic [2:0] ST_DRAIN   = 3'd3;
  localparam logic [2:0] ST_CAPTURE = 3'd4;
  localparam logic [2:0] ST_EMIT    = 3'd5;
  localparam logic [2:0] ST_CLEAR   = 3'd6;

  logic [2:0]           state;
  logic [2:0]           state_nx;
  logic [OUT_W-1:0]     outstanding;
  logic [OUT_W-1:0]     outstanding_nx;
  logic [LEN_WIDTH-1:0] remaining;
  logic [LEN_WIDTH-1:0] remaining_nx;
  logic                 zero_row;
  logic                 gate;
  logic                 accept;
  logic                 done_ok;
  logic                 row_hs;
  logic                 res_hs;
  logic                 err_set;
  logic                 clearing_nx;

  // The element path is a straight wire; only the valid/ready pair is gated.
  assign mac_val  = elem_val;
  assign mac_mult = elem_mult;

  assign res_valid = (state == ST_EMIT);
  assign row_hs    = row_valid && row_ready;
  assign res_hs    = res_valid && res_ready;

  // Issue gating and element handshake: only ISSUE may push work to the MAC.
  always_comb begin
    row_ready    = 1'b0;
    elem_ready   = 1'b0;
    mac_in_valid = 1'b0;
    gate         = 1'b0;
    if (state == ST_IDLE) begin
      row_ready = 1'b1;
    end
    if (state == ST_ISSUE) begin
      gate         = (remaining != '0) && (outstanding < MAX_OUT);
      mac_in_valid = elem_valid && gate;
      elem_ready   = mac_in_ready && gate;
    end
  end

  assign accept = mac_in_valid && mac_in_ready;

  // A done pulse only retires an element when one is actually in flight.
  assign done_ok = mac_done && ((state == ST_ISSUE) || (state == ST_DRAIN))
                   && (outstanding != '0);

  // Done pulses that arrive when nothing can legitimately complete are flagged.
  assign err_set = mac_done &&
                   ((((state == ST_ISSUE) || (state == ST_DRAIN)) && (outstanding == '0)) ||
                    (state == ST_IDLE) || (state == ST_EMIT));

  // In-flight element count: accept adds one, a valid done removes one.
  always_comb begin
    outstanding_nx = outstanding;
    unique case ({accept, done_ok})
      2'b10:   outstanding_nx = outstanding + OUT_W'(1);
      2'b01:   outstanding_nx = outstanding - OUT_W'(1);
      default: outstanding_nx = outstanding;
    endcase
  end

  // Elements still to be accepted for the current row.
  always_comb begin
    remaining_nx = remaining;
    if (row_hs) begin
      remaining_nx = row_len;
    end else if (accept) begin
      remaining_nx = remaining - LEN_WIDTH'(1);
    end
  end

  // Row sequencing: issue, wait for the MAC to drain, capture, emit, clear.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_INIT, ST_CLEAR: begin
        if (mac_done && mac_reset) begin
          state_nx = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (row_hs) begin
          state_nx = (row_len == '0) ? ST_EMIT : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (accept && (remaining == LEN_WIDTH'(1))) begin
          state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (outstanding_nx == '0) begin
          state_nx = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        state_nx = ST_EMIT;
      end
      ST_EMIT: begin
        if (res_hs) begin
          state_nx = zero_row ? ST_IDLE : ST_CLEAR;
        end
      end
      default: state_nx = ST_INIT;
    endcase
  end

  // mac_reset is registered so it stays low during rst and is glitch-free.
  assign clearing_nx = (state_nx == ST_INIT) || (state_nx == ST_CLEAR);

  // State, counters and the MAC clear request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_INIT;
      outstanding <= '0;
      remaining   <= '0;
      mac_reset   <= 1'b0;
    end else begin
      state       <= state_nx;
      outstanding <= outstanding_nx;
      remaining   <= remaining_nx;
      mac_reset   <= clearing_nx;
    end
  end

  // Remember whether the row being emitted was empty, so the MAC is left alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_row <= 1'b0;
    end else if (row_hs) begin
      zero_row <= (row_len == '0);
    end
  end

  // Result register: zero for empty rows, MAC accumulator otherwise; held through EMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_data <= '0;
    end else if (row_hs && (row_len == '0)) begin
      res_data <= '0;
    end else if (state == ST_CAPTURE) begin
      res_data <= mac_acc;
    end
  end

  // Row index advances on every delivered result and wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_row <= '0;
    end else if (res_hs) begin
      res_row <= res_row + ROW_WIDTH'(1);
    end
  end

  // Sticky protocol error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end
  end

`ifdef SPMV_ROW_SCHED_PERF_EN
  // Saturating counters for completed rows and ISSUE cycles lost to back-pressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_rows  <= '0;
      perf_stall <= '0;
    end else begin
      if (res_hs && (perf_rows != '1)) begin
        perf_rows <= perf_rows + 32'd1;
      end
      if ((state == ST_ISSUE) && elem_valid && !accept && (perf_stall != '1)) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/spmv_row_sched.md
Name: spmv_row_sched

Overview:
- Row-level controller for the SpMV multiply-accumulate unit.
- Accepts a per-row nonzero count plus a stream of (val, multiplicand) element pairs, forwards them to the MAC, and tracks in-flight elements.
- After a row drains, captures the MAC accumulator as one row result, then clears the accumulator before the next row.
- Sits between the CSR fetch front-end and the MAC, one instance per MAC lane.

Parameters:
- DATA_WIDTH, 32, multiplicand width; accumulator and val width is 2*DATA_WIDTH.
- LEN_WIDTH, 16, width of the row nonzero count.
- ROW_WIDTH, 16, width of the emitted row index.
- MAX_OUTSTANDING, 8, max elements accepted by the MAC but not yet acknowledged by mac_done; range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- row_len  in  LEN_WIDTH  nonzero count of the next row
- row_valid  in  1  row_len valid
- row_ready  out  1  row_len accepted when row_valid&row_ready
- elem_val  in  2*DATA_WIDTH  element addend operand
- elem_mult  in  DATA_WIDTH  element multiplicand
- elem_valid  in  1  element valid
- elem_ready  out  1  element accepted when elem_valid&elem_ready
- mac_val  out  2*DATA_WIDTH  to MAC val
- mac_mult  out  DATA_WIDTH  to MAC multiplicand
- mac_in_valid  out  1  to MAC in_valid
- mac_in_ready  in  1  from MAC in_ready
- mac_reset  out  1  to MAC accumulator reset
- mac_acc  in  2*DATA_WIDTH  MAC accumulator
- mac_done  in  1  one-cycle pulse per accepted element or completed reset
- res_data  out  2*DATA_WIDTH  row result
- res_row  out  ROW_WIDTH  row index of res_data
- res_valid  out  1  result valid
- res_ready  in  1  result accepted when res_valid&res_ready
- err  out  1  sticky protocol error

Behaviour:
- Reset values: state=INIT, outstanding=0, remaining=0, res_row=0, res_data=0, res_valid=0, row_ready=0, elem_ready=0, mac_in_valid=0, mac_reset=0, err=0.
- INIT: first state after reset. Behaves as CLEAR so that a MAC holding stale state is cleared. Goes to IDLE on mac_done.
- IDLE:
  - row_ready=1.
  - On handshake, latch remaining=row_len.
  - row_len==0: load res_data=0 and go to EMIT.
  - Otherwise go to ISSUE.
- ISSUE:
  - Pass-through: mac_val=elem_val and mac_mult=elem_mult, combinational.
  - gate = (remaining!=0) && (outstanding<MAX_OUTSTANDING).
  - mac_in_valid = elem_valid&gate; elem_ready = mac_in_ready&gate.
  - On accept: remaining-1, outstanding+1.
  - Go to DRAIN when the last element is accepted (remaining 1->0).
- DRAIN: no issue. Go to CAPTURE the cycle outstanding reaches 0 (accounting for a same-cycle mac_done).
- CAPTURE: requires mac_valid-equivalent behaviour, i.e. mac_acc is stable after the last done. Register res_data=mac_acc, then go to EMIT. Latency from last mac_done to res_valid is 2 cycles.
- EMIT:
  - res_valid=1; res_data and res_row are held stable until the handshake.
  - On handshake, res_row increments, wrapping at 2^ROW_WIDTH.
  - Next state: CLEAR for a row_len!=0 row; IDLE for a zero-length row (accumulator untouched).
- CLEAR: mac_reset=1 until mac_done, then go to IDLE. mac_in_valid=0 throughout.
- outstanding bookkeeping:
  - Increment on accept, decrement on mac_done, both in ISSUE and DRAIN.
  - A simultaneous increment and decrement leaves it unchanged.
  - Never exceeds MAX_OUTSTANDING.
- err (sticky, cleared only by rst) is set by:
  - mac_done with outstanding==0 in ISSUE or DRAIN;
  - mac_done in IDLE or EMIT.
  - The offending pulse is otherwise ignored.
- Elements presented while not in ISSUE are back-pressured, never dropped.
- rst mid-row: the partial row is discarded, any in-flight results are lost, and the FSM returns to INIT, which clears the MAC before IDLE.
- res_row continues across rows; it is reset only by rst.

Optional Feature:
- Macro: SPMV_ROW_SCHED_PERF_EN.
- Defined:
  - Adds outputs perf_rows[31:0] (completed rows) and perf_stall[31:0] (cycles in ISSUE with elem_valid=1 but no accept).
  - Both counters saturate at all-ones and reset to 0.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- Reset then init clear: deassert rst, MAC returns done after 3 cycles -> mac_reset high 3 cycles, then row_ready=1, err=0.
- Single row of 4 elements, mac_in_ready=1, mac_done 2 cycles after each accept, mac_acc=64'h10 -> res_valid with res_data=64'h10, res_row=0; then mac_reset pulse; next row gets res_row=1.
- Zero-length row: row_len=0 -> res_valid=1 next cycle, res_data=0, no mac_in_valid and no mac_reset.
- Outstanding limit: MAX_OUTSTANDING=2, row_len=5, mac_done withheld -> exactly 2 accepts, elem_ready=0 until a done arrives, and at most 2 in flight throughout.
- Back-pressure: res_ready=0 for 10 cycles -> res_valid and res_data stable; row_ready=0 and elem_ready=0 during the stall.
- Protocol error and mid-row reset: spurious mac_done in IDLE -> err=1 and sticky; assert rst after 2 of 6 elements -> all outputs at reset values, then INIT clear sequence.
